// File: rtl/regfile_scoreboard.sv
// Register file with configurable read-port count, same-cycle write-to-read
// forwarding and a per-register pending-write scoreboard.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     flush,
    output logic [(2**ADDR_W)-1:0]   busy_vec
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    // Register 0 is hardwired to zero only when ZERO_REG is set.
    logic wr_ok;
    logic rsv_ok;

    logic [ADDR_W-1:0] port_addr [NUM_RD];
    logic              port_hit  [NUM_RD];
    logic              port_zero [NUM_RD];

    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

    // Next-state: data write survives flush; reserve applied after the writeback
    // clear so a new producer to the same register wins.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end
        if (flush) begin
            busy_d = '0;
        end else begin
            if (wr_en) begin
                busy_d[wr_addr] = 1'b0;
            end
            if (rsv_ok) begin
                busy_d[rsv_addr] = 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: forward same-cycle write data and hide the pending flag it resolves.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            port_addr[p] = rd_addr[p*ADDR_W +: ADDR_W];
            port_hit[p]  = (BYPASS != 0) && wr_en && (wr_addr == port_addr[p]);
            port_zero[p] = (ZERO_REG != 0) && (port_addr[p] == '0);
            if (port_zero[p]) begin
                rd_data[p*DATA_W +: DATA_W] = '0;
            end else if (port_hit[p]) begin
                rd_data[p*DATA_W +: DATA_W] = wr_data;
            end else begin
                rd_data[p*DATA_W +: DATA_W] = regs_q[port_addr[p]];
            end
            rd_busy[p] = busy_q[port_addr[p]] && !port_hit[p];
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: a default instance (BYPASS=1, ZERO_REG=1) and an alternate
// instance (BYPASS=0, ZERO_REG=0) share the same stimulus.
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        flush;

    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [31:0] busy_vec_a, busy_vec_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_a)
    );

    regfile_scoreboard #(.ZERO_REG(0), .BYPASS(0)) dut_alt (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rsv_en(rsv_en),
        .rsv_addr(rsv_addr), .flush(flush), .busy_vec(busy_vec_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rsv_en = 0; rsv_addr = 0; flush = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        logic [4:0] a;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            a = i[4:0];
            rd_addr = {a, a};
            #1;
            n_checks++;
            if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0) begin
                n_fail++;
                $display("FAIL reset_data addr %0d got %h/%h want 0", i, rd_data_a, rd_data_b);
            end
            n_checks++;
            if (rd_busy_a !== 2'b00 || rd_busy_b !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_busy addr %0d got %b/%b want 00", i, rd_busy_a, rd_busy_b);
            end
        end
        n_checks++;
        if (busy_vec_a !== 32'h0 || busy_vec_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_busy_vec got %h/%h want 0", busy_vec_a, busy_vec_b);
        end
    endtask

    task automatic test_bypass();
        do_reset();
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        rd_addr = {5'd6, 5'd5};
        #1;
        n_checks++;
        if (rd_data_a[31:0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL bypass_same_cycle got %h want deadbeef", rd_data_a[31:0]);
        end
        n_checks++;
        if (rd_data_b[31:0] !== 32'h0) begin
            n_fail++;
            $display("FAIL nobypass_same_cycle got %h want 0", rd_data_b[31:0]);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_data_a[31:0] !== 32'hDEADBEEF || rd_data_b[31:0] !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL write_next_cycle got %h/%h want deadbeef",
                     rd_data_a[31:0], rd_data_b[31:0]);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
        rsv_en = 1; rsv_addr = 0;
        rd_addr = {5'd0, 5'd0};
        tick();
        idle();
        #1;
        n_checks++;
        if (rd_data_a !== 64'h0 || busy_vec_a[0] !== 1'b0 || rd_busy_a !== 2'b00) begin
            n_fail++;
            $display("FAIL zero_reg_on got data %h bv0 %b busy %b want 0/0/00",
                     rd_data_a, busy_vec_a[0], rd_busy_a);
        end
        n_checks++;
        if (rd_data_b !== 64'h00001234_00001234 || busy_vec_b[0] !== 1'b1 ||
            rd_busy_b !== 2'b11) begin
            n_fail++;
            $display("FAIL zero_reg_off got data %h bv0 %b busy %b want 1234x2/1/11",
                     rd_data_b, busy_vec_b[0], rd_busy_b);
        end
    endtask

    task automatic test_reserve_writeback();
        do_reset();
        rsv_en = 1; rsv_addr = 7;
        tick();
        idle();
        rd_addr = {5'd7, 5'd7};
        for (int c = 1; c <= 3; c++) begin
            #1;
            n_checks++;
            if (rd_busy_a !== 2'b11 || rd_busy_b !== 2'b11 || busy_vec_a !== 32'h80) begin
                n_fail++;
                $display("FAIL pending cycle %0d got %b/%b bv %h want 11/11/80",
                         c, rd_busy_a, rd_busy_b, busy_vec_a);
            end
            tick();
        end
        wr_en = 1; wr_addr = 7; wr_data = 32'h55;
        #1;
        n_checks++;
        if (rd_busy_a !== 2'b00 || rd_data_a !== 64'h00000055_00000055) begin
            n_fail++;
            $display("FAIL wb_bypass got busy %b data %h want 00/55x2", rd_busy_a, rd_data_a);
        end
        n_checks++;
        if (rd_busy_b !== 2'b11 || rd_data_b !== 64'h0) begin
            n_fail++;
            $display("FAIL wb_nobypass got busy %b data %h want 11/0", rd_busy_b, rd_data_b);
        end
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_vec_a !== 32'h0 || busy_vec_b !== 32'h0 || rd_busy_b !== 2'b00 ||
            rd_data_b !== 64'h00000055_00000055) begin
            n_fail++;
            $display("FAIL wb_after got bv %h/%h busy %b data %h want 0/0/00/55x2",
                     busy_vec_a, busy_vec_b, rd_busy_b, rd_data_b);
        end
    endtask

    task automatic test_rsv_wr_same();
        do_reset();
        rsv_en = 1; rsv_addr = 11;
        tick();
        rsv_addr = 9; wr_en = 1; wr_addr = 9; wr_data = 32'h99;
        tick();
        idle();
        rd_addr = {5'd9, 5'd9};
        #1;
        n_checks++;
        if (busy_vec_a !== 32'h0000_0A00 || busy_vec_b !== 32'h0000_0A00) begin
            n_fail++;
            $display("FAIL rsv_wr_same_bv got %h/%h want 00000a00", busy_vec_a, busy_vec_b);
        end
        n_checks++;
        if (rd_data_a[31:0] !== 32'h99 || rd_data_b[31:0] !== 32'h99 || rd_busy_a !== 2'b11) begin
            n_fail++;
            $display("FAIL rsv_wr_same_data got %h/%h busy %b want 99/99/11",
                     rd_data_a[31:0], rd_data_b[31:0], rd_busy_a);
        end
        rsv_en = 1; rsv_addr = 10; wr_en = 1; wr_addr = 11; wr_data = 32'h11;
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_vec_a !== 32'h0000_0600 || busy_vec_b !== 32'h0000_0600) begin
            n_fail++;
            $display("FAIL rsv_wr_diff got %h/%h want 00000600", busy_vec_a, busy_vec_b);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int r = 3; r <= 5; r++) begin
            rsv_en = 1; rsv_addr = r[4:0];
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (busy_vec_a !== 32'h38) begin
            n_fail++;
            $display("FAIL flush_pre got %h want 00000038", busy_vec_a);
        end
        flush = 1; wr_en = 1; wr_addr = 3; wr_data = 32'hA5;
        rsv_en = 1; rsv_addr = 6;
        rd_addr = {5'd4, 5'd3};
        tick();
        idle();
        #1;
        n_checks++;
        if (busy_vec_a !== 32'h0 || busy_vec_b !== 32'h0) begin
            n_fail++;
            $display("FAIL flush_bv got %h/%h want 0", busy_vec_a, busy_vec_b);
        end
        n_checks++;
        if (rd_data_a[31:0] !== 32'hA5 || rd_data_b[31:0] !== 32'hA5) begin
            n_fail++;
            $display("FAIL flush_write got %h/%h want a5", rd_data_a[31:0], rd_data_b[31:0]);
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        wr_en = 1; wr_addr = 12; wr_data = 32'hC;
        rsv_en = 1; rsv_addr = 13;
        tick();
        rst = 1; wr_addr = 15; wr_data = 32'hF; rsv_addr = 14;
        tick();
        idle();
        rd_addr = {5'd15, 5'd12};
        #1;
        n_checks++;
        if (rd_data_a !== 64'h0 || rd_data_b !== 64'h0 || busy_vec_a !== 32'h0 ||
            busy_vec_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_midstream got %h/%h bv %h/%h want all 0",
                     rd_data_a, rd_data_b, busy_vec_a, busy_vec_b);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] a;
        do_reset();
        for (int i = 20; i <= 23; i++) begin
            a = i[4:0];
            wr_en = 1; wr_addr = a; wr_data = 32'h1000 + i;
            rd_addr = {5'd20, a};
            #1;
            n_checks++;
            if (rd_data_a[31:0] !== 32'h1000 + i) begin
                n_fail++;
                $display("FAIL b2b_bypass addr %0d got %h want %h",
                         i, rd_data_a[31:0], 32'h1000 + i);
            end
            tick();
        end
        idle();
        rd_addr = {5'd23, 5'd20};
        #1;
        n_checks++;
        if (rd_data_a !== 64'h00001017_00001014 || rd_data_b !== 64'h00001017_00001014) begin
            n_fail++;
            $display("FAIL b2b_readback got %h/%h want 0000101700001014", rd_data_a, rd_data_b);
        end
        rd_addr = {5'd21, 5'd21};
        #1;
        n_checks++;
        if (rd_data_a !== 64'h00001015_00001015 || rd_busy_a !== 2'b00) begin
            n_fail++;
            $display("FAIL same_addr_ports got %h busy %b want 1015x2/00", rd_data_a, rd_busy_a);
        end
    endtask

    initial begin
        idle();
        rd_addr = '0;
        test_reset();
        test_bypass();
        test_zero_reg();
        test_reserve_writeback();
        test_rsv_wr_same();
        test_flush();
        test_reset_midstream();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
